// File: rtl/banderin_ctrl.sv
// banderin_ctrl: sprint race-sequence controller driving the finish flag servo command and stopwatch gate
// Ports: clk, reset (async, active-high); btn_arm, btn_go, sensor_meta raw async inputs;
//        comando_banderin (1 = flag up), race_running, race_done (1-cycle pulse), state_o (FSM state).
// Optional feature macro: BANDERIN_LOCKOUT_EN (finish lockout for MIN_RUN_MS after entering RUNNING).
module banderin_ctrl #(
  parameter int CLK_FREQ_HZ   = 25_000_000,
  parameter int DEBOUNCE_CLKS = 250_000,
  parameter int FLAG_HOLD_MS  = 3000,
  parameter int MIN_RUN_MS    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_arm,
  input  logic       btn_go,
  input  logic       sensor_meta,
  output logic       comando_banderin,
  output logic       race_running,
  output logic       race_done,
  output logic [1:0] state_o
);
  localparam int CLKS_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int MAX_MS      = (FLAG_HOLD_MS > MIN_RUN_MS) ? FLAG_HOLD_MS : MIN_RUN_MS;
  localparam int DW          = $clog2(DEBOUNCE_CLKS + 1);
  localparam int PW          = $clog2(CLKS_PER_MS + 1);
  localparam int MW          = $clog2(MAX_MS + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUNNING = 2'd2, FINISH = 2'd3} state_t;
  state_t state, state_n;
  logic [2:0] raw, ev;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms;
  logic ms_tick, hold_done, run_ok, cmd_n, run_n, done_n;
  assign raw = {sensor_meta, btn_go, btn_arm};
  // Per input: 2-FF sync, debounce to a stable level, then rising-edge event.
  for (genvar i = 0; i < 3; i++) begin : g_cond
    logic s1, s2, deb, deb_d;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        deb   <= 1'b0;
        deb_d <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        deb_d <= deb;
        if (s2 == deb) cnt <= '0;
        else if (cnt == DW'(DEBOUNCE_CLKS - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
    assign ev[i] = deb & ~deb_d;
  end
  // Prescaler restarts on every state change so ms periods align with the transition.
  assign ms_tick   = pre == PW'(CLKS_PER_MS - 1);
  assign hold_done = ms_tick && ms == MW'(FLAG_HOLD_MS - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      ms  <= '0;
    end else if (state_n != state) begin
      pre <= '0;
      ms  <= '0;
    end else begin
      pre <= ms_tick ? '0 : pre + 1'b1;
      if (ms_tick && ms != MW'(MAX_MS)) ms <= ms + 1'b1;
    end
  end
`ifdef BANDERIN_LOCKOUT_EN
  assign run_ok = ms >= MW'(MIN_RUN_MS);
`else
  assign run_ok = 1'b1;
`endif
  // Events not consumed by the current state are dropped; go wins over arm in ARMED.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ev[0] ? ARMED : IDLE;
      ARMED:   state_n = ev[1] ? RUNNING : (ev[0] ? IDLE : ARMED);
      RUNNING: state_n = (ev[2] && run_ok) ? FINISH : RUNNING;
      default: state_n = hold_done ? IDLE : FINISH;
    endcase
    cmd_n  = state_n == ARMED || state_n == FINISH;
    run_n  = state_n == RUNNING;
    done_n = state == RUNNING && state_n == FINISH;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      comando_banderin <= 1'b0;
      race_running     <= 1'b0;
      race_done        <= 1'b0;
    end else begin
      state            <= state_n;
      comando_banderin <= cmd_n;
      race_running     <= run_n;
      race_done        <= done_n;
    end
  end
  assign state_o = state;
endmodule

// File: tb/tb_banderin_ctrl.sv
// tb_banderin_ctrl: scoreboard bench for banderin_ctrl; expected output changes are queued with their cycle
module tb_banderin_ctrl;
  logic clk, reset, btn_arm, btn_go, sensor_meta;
  logic comando_banderin, race_running, race_done;
  logic [1:0] state_o;
  int cyc, checks, passes;
  logic mon_en;
  logic [4:0] cur, prev;
  typedef struct {int at; logic [4:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  banderin_ctrl #(
    .CLK_FREQ_HZ(10_000),
    .DEBOUNCE_CLKS(4),
    .FLAG_HOLD_MS(3),
    .MIN_RUN_MS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_arm(btn_arm),
    .btn_go(btn_go),
    .sensor_meta(sensor_meta),
    .comando_banderin(comando_banderin),
    .race_running(race_running),
    .race_done(race_done),
    .state_o(state_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [4:0] st_v(input logic [1:0] s);
    return {s, s == 2'd1 || s == 2'd3, s == 2'd2, 1'b0};
  endfunction
  function automatic void push(input int at, input logic [4:0] v);
    exp_t x;
    x.at = at;
    x.v  = v;
    sb.push_back(x);
  endfunction
  function automatic void push_finish(input int f);
    push(f, 5'b11_1_0_1);
    push(f + 1, 5'b11_1_0_0);
    push(f + 30, st_v(2'd0));
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_n(input int n);
    repeat (n) step();
  endtask
  task automatic set_in(input int ch, input logic v);
    if (ch == 0) btn_arm = v;
    else if (ch == 1) btn_go = v;
    else sensor_meta = v;
  endtask
  task automatic press(input int ch, input int hold);
    set_in(ch, 1'b1);
    wait_n(hold);
    set_in(ch, 1'b0);
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({state_o, comando_banderin, race_running, race_done} !== 5'b0)
      $display("FAIL %s got=%b required=00000", name, {state_o, comando_banderin, race_running, race_done});
    else passes++;
  endtask
  task automatic pulse_reset(input string name);
    push(cyc + 1, st_v(2'd0));
    reset = 1'b1;
    #1;
    check_zero(name);
    wait_n(1);
    reset = 1'b0;
  endtask
  // Monitor: every change on the outputs must match the next queued expectation, value and cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {state_o, comando_banderin, race_running, race_done};
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
        else begin
          e = sb.pop_front();
          if (e.v !== cur || e.at != cyc)
            $display("FAIL output_change got=%b@%0d required=%b@%0d", cur, cyc, e.v, e.at);
          else passes++;
        end
        prev = cur;
      end
    end
  end
  initial begin
    int t, r, f;
    checks = 0;
    passes = 0;
    mon_en = 1'b0;
    prev = 5'b0;
    reset = 1'b1;
    btn_arm = 1'b0;
    btn_go = 1'b0;
    sensor_meta = 1'b0;
    wait_n(3);
    check_zero("reset_state");
    reset = 1'b0;
    mon_en = 1'b1;
    wait_n(5);
    // normal race
    t = cyc; push(t + 7, st_v(2'd1)); press(0, 10); wait_n(10);
    t = cyc; push(t + 7, st_v(2'd2)); press(1, 10); wait_n(20);
    t = cyc; push_finish(t + 7); press(2, 10); wait_n(35);
    // bounce on arm, then stable
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1); wait_n(2);
      set_in(0, 1'b0); wait_n(2);
    end
    t = cyc; push(t + 7, st_v(2'd1)); press(0, 10); wait_n(10);
    // 3-clock glitch in ARMED must not cancel
    press(0, 3); wait_n(15);
    // go, arm and finish together in ARMED: go wins, finish dropped
    t = cyc; push(t + 7, st_v(2'd2));
    btn_go = 1'b1; btn_arm = 1'b1; sensor_meta = 1'b1;
    wait_n(10);
    btn_go = 1'b0; btn_arm = 1'b0; sensor_meta = 1'b0;
    wait_n(25);
    // arm and go ignored in RUNNING
    press(0, 10); wait_n(10);
    press(1, 10); wait_n(15);
    // reset while RUNNING
    pulse_reset("reset_in_running");
    wait_n(5);
    // go ignored in IDLE
    press(1, 10); wait_n(15);
    // arm works after reset; race to FINISH, reset 10 clocks in
    t = cyc; push(t + 7, st_v(2'd1)); press(0, 10); wait_n(5);
    t = cyc; push(t + 7, st_v(2'd2)); press(1, 10); wait_n(20);
    t = cyc; f = t + 7;
    push(f, 5'b11_1_0_1);
    push(f + 1, 5'b11_1_0_0);
    press(2, 10);
    wait_n(f + 10 - cyc);
    pulse_reset("reset_in_finish");
    wait_n(5);
    // early finish: lockout drops it, otherwise accepted
    t = cyc; push(t + 7, st_v(2'd1)); press(0, 10); wait_n(5);
    t = cyc; r = t + 7; push(r, st_v(2'd2)); press(1, 10);
    wait_n(r + 5 - cyc);
`ifdef BANDERIN_LOCKOUT_EN
    press(2, 10);
    wait_n(r + 25 - cyc);
    f = cyc + 7; push_finish(f); press(2, 10);
`else
    f = cyc + 7; push_finish(f); press(2, 10);
`endif
    // any input in FINISH is ignored and never replays
    press(0, 5);
    press(1, 5);
    press(2, 5);
    wait_n(50);
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/banderin_ctrl.md
# banderin_ctrl

Race-sequence controller for the sprint stopwatch. It conditions the raw arm, go and finish-sensor inputs: 2-FF synchronisation, debounce, then rising-edge detection. A four-state FSM uses these events to drive `comando_banderin` into the servo PWM stage directly downstream, and to gate the stopwatch through `race_running`. The finish flag is held up for a fixed time, measured by an internal millisecond prescaler.

## Interface
- `CLK_FREQ_HZ`, default 25_000_000: clock frequency. `CLKS_PER_MS = CLK_FREQ_HZ/1000`, which gives 25_000.
- `DEBOUNCE_CLKS`, default 250_000 (10 ms): consecutive stable cycles required before a debounced level changes. Must be ≥ 1.
- `FLAG_HOLD_MS`, default 3000: time the flag stays up after a finish.
- `MIN_RUN_MS`, default 500: finish lockout window. Used only with `BANDERIN_LOCKOUT_EN`.
- `clk` input 1: system clock, 25 MHz.
- `reset` input 1: asynchronous, active-high.
- `btn_arm` input 1: raw arm/cancel button, active-high, asynchronous.
- `btn_go` input 1: raw start button, active-high, asynchronous.
- `sensor_meta` input 1: raw finish-line sensor, active-high, asynchronous.
- `comando_banderin` output 1: 1 = flag up (90°), 0 = flag down (0°). Feeds `servo_pwm`.
- `race_running` output 1: high while the race is being timed.
- `race_done` output 1: one-cycle pulse when a valid finish is accepted.
- `state_o` output 2: current FSM state encoding, for debug and display.

## Operation
- **Conditioning.** Each of the three inputs has its own conditioning channel.
  - The input passes through 2 flops (`s2`).
  - A debounce counter counts cycles while `s2 != deb`. It clears whenever `s2 == deb`.
  - When the count reaches `DEBOUNCE_CLKS-1` and `s2 != deb` still holds, `deb <= s2` and the counter clears.
  - Event = `deb & ~deb_d`, a 0→1 transition only. Falling edges produce no event.
- **FSM states** (`state_o` encoding) and their outputs:
  - IDLE = 0: `comando_banderin` = 0, `race_running` = 0.
  - ARMED = 1: `comando_banderin` = 1, `race_running` = 0.
  - RUNNING = 2: `comando_banderin` = 0, `race_running` = 1.
  - FINISH = 3: `comando_banderin` = 1, `race_running` = 0.
- **Transitions:**
  - IDLE + arm event → ARMED.
  - ARMED + go event → RUNNING.
  - ARMED + arm event → IDLE (cancel).
  - RUNNING + finish event → FINISH. `race_done` pulses for exactly 1 cycle, coincident with the state change.
  - FINISH + hold expiry → IDLE.
  - All other events in any state are ignored and are not queued.
- **Simultaneous events:**
  - ARMED: go takes priority over arm.
  - ARMED: a finish arriving with go is ignored.
  - RUNNING: arm and go are always ignored.
- **Millisecond prescaler:**
  - Counts 0…`CLKS_PER_MS-1` and emits `ms_tick` on the terminal count.
  - Cleared on every state entry, so a period starts aligned to the transition.
  - The ms counter is wide enough for `max(FLAG_HOLD_MS, MIN_RUN_MS)`. It saturates and never wraps.
- **Hold expiry.** FINISH lasts exactly `FLAG_HOLD_MS*CLKS_PER_MS` cycles, then the FSM returns to IDLE.
- **Reset.** Asynchronous reset at any point, including mid-race or mid-hold, forces:
  - state IDLE;
  - all outputs 0;
  - all sync, debounce, edge and timer registers 0.
  - An input already held high when reset releases produces an event once it has been debounced.

## Timing
- All outputs are registered.
- Latency from a raw input edge that then stays stable to the FSM/output change is exactly `DEBOUNCE_CLKS + 3` clocks:
  - 2 clocks synchroniser;
  - `DEBOUNCE_CLKS` clocks debounce;
  - 1 clock FSM.
- Glitch rejection: a pulse or bounce shorter than `DEBOUNCE_CLKS` cycles at `s2` produces no event.
- `comando_banderin` changes in the same cycle as `state_o`. `servo_pwm` picks it up at its next PWM period; no handshake is used.
- `race_done` is high for exactly one clock per accepted finish.
- Minimum FINISH dwell: `FLAG_HOLD_MS*CLKS_PER_MS` clocks. Maximum: the same value; the dwell is exact.

## Configuration
- Macro: `BANDERIN_LOCKOUT_EN`.
- **Defined:**
  - A finish event in RUNNING is accepted only after `MIN_RUN_MS` complete ms ticks have elapsed since entering RUNNING.
  - Earlier finish events are discarded; the state stays RUNNING and `race_done` does not pulse.
- **Undefined:**
  - Any finish event in RUNNING is accepted immediately.
  - `MIN_RUN_MS` has no effect, and the lockout counter is not synthesised.

## Test plan
Parameters for simulation: `CLK_FREQ_HZ` = 10_000, `DEBOUNCE_CLKS` = 4, `FLAG_HOLD_MS` = 3, `MIN_RUN_MS` = 2.
1. **Normal race.**
   - Stimulus: arm, then go, then finish, each held for 10 clocks.
   - Required: `state_o` sequence 0→1→2→3→0; `comando_banderin` sequence 0→1→0→1→0.
   - Each transition occurs exactly 7 clocks after its raw edge.
   - `race_done` high for 1 clock.
   - FINISH lasts 30 clocks.
2. **Bounce.**
   - Stimulus: `btn_arm` toggles every 2 clocks for 20 clocks, then stays high.
   - Required: exactly one ARMED entry, 7 clocks after the final stable edge.
   - A 3-clock glitch produces no transition.
3. **Simultaneous go and arm in ARMED.**
   - Stimulus: raw edges on `btn_go` and `btn_arm` in the same clock.
   - Required: state goes to RUNNING, not IDLE.
4. **Reset mid-operation.**
   - Stimulus: `reset` asserted for 1 clock while in RUNNING, and again in a separate run 10 clocks into FINISH.
   - Required: immediate IDLE with all outputs 0.
   - A subsequent arm works normally.
5. **Lockout** (`BANDERIN_LOCKOUT_EN` defined).
   - Stimulus: finish edge 5 clocks after entering RUNNING.
   - Required: ignored; no `race_done`.
   - A finish edge after 25 clocks is accepted.
   - With the macro undefined, the first finish edge is accepted.
6. **Ignored events.**
   - Stimulus: go in IDLE; arm/go in RUNNING; any input in FINISH.
   - Required: `state_o` unchanged, and no pending event fires later.
